// File: rtl/stack_multi_ch_pkg.sv
// Shared types for the multi-channel stack.
// Command encoding and width helpers.
package stack_multi_ch_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_BYP,
    CMD_PUSH,
    CMD_POP,
    CMD_PEEK
  } cmd_e;

  function automatic int clog2w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stack_multi_ch_rf1.sv
// Single-port register file, one access per cycle.
// Read data is registered (1-cycle latency).
module rf1_MxN #(
  parameter int DEPTH = 512,
  parameter int W     = 8,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          En,
  input  logic          Wr,
  input  logic [AW-1:0] Addr,
  input  logic [W-1:0]  WrData,
  output logic [W-1:0]  Data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (En) begin
      if (Wr) mem_q[Addr] <= WrData;
      else    Data <= mem_q[Addr];
    end
  end

endmodule

// File: rtl/stack_multi_ch.sv
// NCH independent LIFO stacks sharing one single-port RAM.
// Supports clear, push+pop bypass, peek and error pulses.
module stack_multi_ch
  import stack_multi_ch_pkg::*;
#(
  parameter int M     = 128,
  parameter int N     = 8,
  parameter int WIDTH = clog2w(M),
  parameter int NCH   = 4,
  parameter int CW    = clog2w(NCH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [CW-1:0]  ch,
  input  logic           push,
  input  logic [N-1:0]   push_data,
  input  logic           pop,
  input  logic           peek,
  input  logic           clr,
  output logic [NCH-1:0] full,
  output logic [NCH-1:0] empty,
  output logic [WIDTH:0] level,
  output logic [N-1:0]   pop_data,
  output logic           valid,
  output logic [CW-1:0]  valid_ch,
  output logic           err_ovf,
  output logic           err_udf
);

  localparam logic [WIDTH:0] MAXC = (WIDTH+1)'(M);

  logic [WIDTH:0]   cnt_q [NCH];
  logic [WIDTH:0]   cnt_d [NCH];
  logic [WIDTH:0]   cur;
  logic [WIDTH-1:0] top_slot;
  logic             cur_full, cur_empty;
  cmd_e             cmd;

  logic             ram_en, ram_wr;
  logic [CW+WIDTH-1:0] ram_addr;
  logic [N-1:0]     ram_data;

  logic             valid_q, valid_d;
  logic [CW-1:0]    valid_ch_q;
  logic             byp_q, byp_d;
  logic [N-1:0]     byp_data_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  assign cur       = cnt_q[ch];
  assign cur_full  = (cur == MAXC);
  assign cur_empty = (cur == '0);
  assign top_slot  = cur[WIDTH-1:0] - 1'b1;

  // Priority resolution of overlapping command bits.
  always_comb begin
    cmd = CMD_NONE;
    if (clr)              cmd = CMD_CLR;
    else if (push && pop) cmd = CMD_BYP;
    else if (push)        cmd = CMD_PUSH;
    else if (pop)         cmd = CMD_POP;
    else if (peek)        cmd = CMD_PEEK;
  end

  always_comb begin
    cnt_d    = cnt_q;
    ram_en   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = {ch, cur[WIDTH-1:0]};
    valid_d  = 1'b0;
    byp_d    = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    unique case (cmd)
      CMD_CLR: cnt_d[ch] = '0;
      CMD_BYP: begin
        valid_d = 1'b1;
        byp_d   = 1'b1;
      end
      CMD_PUSH: begin
        if (cur_full) ovf_d = 1'b1;
        else begin
          ram_en    = 1'b1;
          ram_wr    = 1'b1;
          cnt_d[ch] = cur + 1'b1;
        end
      end
      CMD_POP, CMD_PEEK: begin
        if (cur_empty) udf_d = 1'b1;
        else begin
          ram_en   = 1'b1;
          ram_addr = {ch, top_slot};
          valid_d  = 1'b1;
          if (cmd == CMD_POP) cnt_d[ch] = cur - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
      valid_q    <= 1'b0;
      valid_ch_q <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      byp_q   <= byp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      if (valid_d) valid_ch_q <= ch;
      if (byp_d)   byp_data_q <= push_data;
    end
  end

  rf1_MxN #(
    .DEPTH(NCH*M),
    .W    (N),
    .AW   (CW+WIDTH)
  ) u_rf (
    .clk   (clk),
    .En    (ram_en),
    .Wr    (ram_wr),
    .Addr  (ram_addr),
    .WrData(push_data),
    .Data  (ram_data)
  );

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      full[c]  = (cnt_q[c] == MAXC);
      empty[c] = (cnt_q[c] == '0);
    end
  end

  // RAM read register is unreset, so gate the output until valid.
  assign pop_data = valid_q ? (byp_q ? byp_data_q : ram_data) : '0;
  assign level    = cur;
  assign valid    = valid_q;
  assign valid_ch = valid_ch_q;
  assign err_ovf  = ovf_q;
  assign err_udf  = udf_q;

endmodule

// File: tb/tb_stack_multi_ch.sv
// Randomized and directed bench for stack_multi_ch.
// Reference model: per-channel arrays with plain counts.
module tb_stack_multi_ch;

  localparam int M   = 128;
  localparam int N   = 8;
  localparam int W   = 7;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk = 0;
  logic           reset_n;
  logic [CW-1:0]  ch;
  logic           push, pop, peek, clr;
  logic [N-1:0]   push_data;
  logic [NCH-1:0] full, empty;
  logic [W:0]     level;
  logic [N-1:0]   pop_data;
  logic           valid;
  logic [CW-1:0]  valid_ch;
  logic           err_ovf, err_udf;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] mdat [NCH][M];
  int           mcnt [NCH];

  stack_multi_ch #(
    .M(M), .N(N), .WIDTH(W), .NCH(NCH), .CW(CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ch       (ch),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .peek     (peek),
    .clr      (clr),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .pop_data (pop_data),
    .valid    (valid),
    .valid_ch (valid_ch),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
  endtask

  task automatic chk_flags();
    logic [NCH-1:0] ef, ee;
    for (int c = 0; c < NCH; c++) begin
      ef[c] = (mcnt[c] == M);
      ee[c] = (mcnt[c] == 0);
    end
    chk("full", full, ef);
    chk("empty", empty, ee);
  endtask

  // One command cycle; entered and left at a falling edge.
  task automatic step(input int c, input bit pu, input logic [N-1:0] d,
                      input bit po, input bit pk, input bit cl);
    bit           ev, eo, eu;
    logic [N-1:0] ed;
    ch = CW'(c); push = pu; push_data = d;
    pop = po; peek = pk; clr = cl;
    #1;
    chk("level", level, mcnt[c]);
    ev = 0; eo = 0; eu = 0; ed = '0;
    if (cl) mcnt[c] = 0;
    else if (pu && po) begin ev = 1; ed = d; end
    else if (pu) begin
      if (mcnt[c] == M) eo = 1;
      else begin mdat[c][mcnt[c]] = d; mcnt[c]++; end
    end else if (po || pk) begin
      if (mcnt[c] == 0) eu = 1;
      else begin
        ev = 1;
        ed = mdat[c][mcnt[c]-1];
        if (po) mcnt[c]--;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid", valid, ev);
    chk("err_ovf", err_ovf, eo);
    chk("err_udf", err_udf, eu);
    if (ev) begin
      chk("pop_data", pop_data, ed);
      chk("valid_ch", valid_ch, c);
    end
    chk_flags();
  endtask

  task automatic idle(input int c);
    step(c, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    reset_n = 0;
    ch = 0; push = 0; pop = 0; peek = 0; clr = 0; push_data = 0;
    model_reset();
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_level", level, 0);
    chk("rst_valid_ch", valid_ch, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_udf", err_udf, 0);
    chk_flags();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    step(0, 1, 8'h11, 0, 0, 0);
    step(0, 1, 8'h22, 0, 0, 0);
    step(0, 1, 8'h33, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, 0);
    idle(0);

    step(1, 1, 8'hA0, 0, 0, 0);
    step(2, 1, 8'hB0, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(2, 0, 8'h00, 1, 0, 0);
    step(3, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < M; i++) step(0, 1, N'(i + 3), 0, 0, 0);
    step(0, 1, 8'hEE, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);

    step(3, 0, 8'h00, 1, 0, 0);
    step(3, 0, 8'h00, 0, 1, 0);
    step(3, 1, 8'h5A, 0, 0, 0);
    step(3, 0, 8'h00, 0, 1, 0);
    step(3, 0, 8'h00, 0, 1, 0);
    step(3, 1, 8'h5B, 0, 1, 0);
    step(3, 0, 8'h00, 1, 1, 0);

    step(2, 1, 8'h42, 0, 0, 0);
    step(2, 1, 8'h77, 1, 0, 0);
    step(2, 0, 8'h00, 1, 0, 0);
    step(2, 1, 8'h99, 1, 1, 0);
    step(2, 1, 8'h98, 1, 0, 0);

    for (int i = 0; i < 5; i++) step(1, 1, N'(8'hC0 + i), 0, 0, 0);
    step(1, 1, 8'hFF, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int  c, r;
      c = $urandom_range(0, NCH-1);
      r = $urandom_range(0, 99);
      step(c, r < 45 || (r >= 90 && r < 94),
           N'($urandom), (r >= 45 && r < 80) || (r >= 90 && r < 94),
           (r >= 80 && r < 90) || r == 94 || r == 95, r >= 98);
    end

    step(0, 1, 8'h61, 0, 0, 0);
    step(0, 1, 8'h62, 0, 0, 0);
    ch = 0; push = 0; pop = 1; peek = 0; clr = 0;
    @(posedge clk);
    #1;
    pop = 0;
    reset_n = 0;
    #1;
    model_reset();
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_pop_data", pop_data, 0);
    chk("mid_rst_ovf", err_ovf, 0);
    chk("mid_rst_udf", err_udf, 0);
    chk_flags();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 1, 8'h7E, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
